// File: rtl/sbox_pkg.sv
// Shared types, defaults and GF(2^8) helpers for the AES S-box pipeline.
package sbox_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_LANES  = 4;
    localparam int DEF_STAGES = 2;

    // Constant added by the forward affine transform
    localparam byte_t AFFINE_C     = 8'h63;
    // Constant added by the inverse affine transform
    localparam byte_t INV_AFFINE_C = 8'h05;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero naturally maps to zero
    function automatic byte_t gf_inv(input byte_t a);
        byte_t a2, a3, a6, a7, a14, a15, a30, a31, a62, a63, a126, a127;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a7   = gf_mul(a6, a);
        a14  = gf_mul(a7, a7);
        a15  = gf_mul(a14, a);
        a30  = gf_mul(a15, a15);
        a31  = gf_mul(a30, a);
        a62  = gf_mul(a31, a31);
        a63  = gf_mul(a62, a);
        a126 = gf_mul(a63, a63);
        a127 = gf_mul(a126, a);
        return gf_mul(a127, a127);
    endfunction

    function automatic byte_t rotl(input byte_t a, input int n);
        return byte_t'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic byte_t affine_fwd(input byte_t a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ AFFINE_C;
    endfunction

    function automatic byte_t affine_inv(input byte_t a);
        return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/sbox_pipe_lane.sv
// Single-byte AES forward/inverse S-box, purely combinational.
module sbox_lane
    import sbox_pkg::*;
(
    input  logic [7:0] byte_val,
    input  logic       encrypt,
    output logic [7:0] sub_val
);

    byte_t pre_byte;
    byte_t inv_byte;

    // Inverse affine ahead of inversion for decrypt, forward affine after it for encrypt
    always_comb begin
        pre_byte = encrypt ? byte_val : affine_inv(byte_val);
        inv_byte = gf_inv(pre_byte);
        sub_val  = encrypt ? affine_fwd(inv_byte) : inv_byte;
    end

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane AES S-box with a bubble-collapsing valid/ready register pipeline.
module sbox_pipe
    import sbox_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_encrypt,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_encrypt,
    output logic [8*LANES-1:0]   out_data,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    logic [W-1:0]      sub_data;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] enc_vec;
    logic [W-1:0]      data_vec [STAGES];

    // Substitution sits ahead of stage 0, one lane instance per byte
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            sbox_lane u_lane (
                .byte_val (in_data[8*gi +: 8]),
                .encrypt  (in_encrypt),
                .sub_val  (sub_data[8*gi +: 8])
            );
        end
    endgenerate

    // A stage loads when it or any later stage is empty, or the output drains
    always_comb begin
        logic hole;
        load = '0;
        for (int i = 0; i < STAGES; i++) begin
            hole = out_ready;
            for (int j = i; j < STAGES; j++) begin
                hole = hole | ~valid_vec[j];
            end
            load[i] = hole;
        end
    end

    assign in_ready = load[0] & ~flush;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic         stage_valid_reg;
            logic         stage_enc_reg;
            logic [W-1:0] stage_data_reg;
            logic         feed_valid;
            logic         feed_enc;
            logic [W-1:0] feed_data;

            if (gi == 0) begin : g_head
                assign feed_valid = in_valid & in_ready;
                assign feed_enc   = in_encrypt;
                assign feed_data  = sub_data;
            end else begin : g_body
                assign feed_valid = valid_vec[gi-1];
                assign feed_enc   = enc_vec[gi-1];
                assign feed_data  = data_vec[gi-1];
            end

            // Stage register: flush drops validity only, payload follows load
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_valid_reg <= 1'b0;
                    stage_enc_reg   <= 1'b0;
                    stage_data_reg  <= '0;
                end else if (flush) begin
                    stage_valid_reg <= 1'b0;
                end else if (load[gi]) begin
                    stage_valid_reg <= feed_valid;
                    stage_enc_reg   <= feed_enc;
                    stage_data_reg  <= feed_data;
                end
            end

            assign valid_vec[gi] = stage_valid_reg;
            assign enc_vec[gi]   = stage_enc_reg;
            assign data_vec[gi]  = stage_data_reg;
        end
    endgenerate

    assign out_valid   = valid_vec[STAGES-1] & ~flush;
    assign out_encrypt = enc_vec[STAGES-1];
    assign out_data    = data_vec[STAGES-1];
    assign busy        = |valid_vec;

endmodule

// File: doc/sbox_pipe.md
SBOX_PIPE -- requirements
Module: sbox_pipe

Interface
REQ-001 Parameter LANES, default 4, number of byte lanes processed in parallel (1..16).
REQ-002 Parameter STAGES, default 2, pipeline register stages (1..8); latency in cycles.
REQ-003 Ports: clk and reset_n; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous clear of all in-flight transactions.
REQ-007 in_valid  input  1  upstream presents a transaction.
REQ-008 in_ready  output  1  block accepts the transaction this cycle.
REQ-009 in_encrypt  input  1  1 = forward S-box, 0 = inverse S-box, per transaction.
REQ-010 in_data  input  8*LANES  input bytes; lane k = bits [8k+7:8k].
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_encrypt  output  1  mode bit travelling with the result.
REQ-014 out_data  output  8*LANES  substituted bytes, lane order preserved.
REQ-015 busy  output  1  any stage holds a valid transaction.

Function
REQ-016 Each lane SHALL compute the AES S-box (encrypt=1) or inverse S-box (encrypt=0): GF(2^8) inversion (0 maps to 0) with the affine transform applied after inversion for encrypt and the inverse affine applied before inversion for decrypt.
REQ-017 Substitution SHALL be combinational ahead of stage 0; stages 1..STAGES-1 carry data, mode and valid unchanged.
REQ-018 A transfer in SHALL occur when in_valid and in_ready are both 1 on a rising edge; a transfer out when out_valid and out_ready are both 1.
REQ-019 Stage i SHALL load when its valid bit is 0 or stage i+1 loads in the same cycle; the last stage loads when its valid bit is 0 or out_ready=1 (bubble collapsing).
REQ-020 in_ready SHALL equal the stage-0 load condition and SHALL be 0 while flush=1.
REQ-021 With out_ready held 1, an accepted transaction SHALL appear on out_valid exactly STAGES cycles after acceptance; throughput one transaction per cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_encrypt SHALL remain stable, and no transaction SHALL be dropped or duplicated.
REQ-023 When full (all valid bits set) with out_ready=1, accepting a new input and emitting an output SHALL occur in the same cycle.
REQ-024 Transactions SHALL leave in acceptance order; mixed encrypt/decrypt transactions in flight SHALL each use their own mode bit.
REQ-025 flush=1 SHALL force out_valid=0 that cycle and clear every valid bit at the next edge; data registers need not be cleared.
REQ-026 flush=1 SHALL take precedence over simultaneous in_valid/out_ready activity.
REQ-027 out_valid SHALL equal the last stage valid bit; busy SHALL be the OR of all valid bits.
REQ-028 in_valid asserted with in_ready=0 SHALL not be captured; upstream holds.

Reset
REQ-029 reset_n=0 SHALL immediately clear all valid bits, data and mode registers to 0: out_valid=0, out_data=0, out_encrypt=0, busy=0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset_n deasserts with flush=0.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions without emitting them.

Structure
REQ-032 Shared package sbox_pkg SHALL hold the byte type, default LANES/STAGES and the affine constant 0x63.
REQ-033 One sub-module, sbox_lane (8-bit in, encrypt, 8-bit out, purely combinational), SHALL be instantiated LANES times.
REQ-034 Pipeline stages SHALL be generated from STAGES; no hand-unrolled stages.

Verification
REQ-035 LANES=4, STAGES=2, in_data=0x53_01_00_00, encrypt=1, out_ready=1 -> out_data=0xED_7C_63_63, out_valid 2 cycles after acceptance.
REQ-036 in_data=0xED_7C_63_63, encrypt=0 -> out_data=0x53_01_00_00, out_encrypt=0.
REQ-037 Stream 10 back-to-back alternating-mode transactions, out_ready=1 -> 10 results in order, one per cycle, in_ready constantly 1.
REQ-038 Hold out_ready=0 for 5 cycles while streaming -> in_ready drops after STAGES accepts; out_data stable; all results appear once on release.
REQ-039 flush=1 with pipeline full -> out_valid=0 that cycle, busy=0 next cycle, no flushed result ever emitted.
REQ-040 reset_n pulsed low mid-stream -> outputs 0 asynchronously; in_ready=1 one cycle after release; exhaustive 256-value sweep per mode matches the AES table.
